muxpga_cfg_loader: RTL

MUXPGA_CFG_LOADER -- requirements
Module: muxpga_cfg_loader

---
 rtl/muxpga_cfg_loader_if.sv | 15 +
 rtl/muxpga_cfg_loader.sv | 94 +++++++++
 2 files changed

// File: rtl/muxpga_cfg_loader_if.sv
// muxpga_cfg_loader_if: host control, byte stream and fabric command bundle for the configuration loader
interface muxpga_cfg_loader_if;
  logic       start;
  logic       abort;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] cfg_cmd;
  logic [3:0] cfg_nib;
  logic       busy;
  logic       done;
  logic       error;
  modport master(output start, abort, in_data, in_valid, input in_ready, cfg_cmd, cfg_nib, busy, done, error);
  modport slave(input start, abort, in_data, in_valid, output in_ready, cfg_cmd, cfg_nib, busy, done, error);
endinterface

// File: rtl/muxpga_cfg_loader.sv
// muxpga_cfg_loader: streams a host bitstream into the fabric as nibble SHIFTs framed by CLEAR/COMMIT.
// Define MUXPGA_CFG_CRC_EN to require a CRC-8 trailer byte before COMMIT.
module muxpga_cfg_loader #(
  parameter int NUM_BYTES = 16,
  parameter int TIMEOUT   = 255
) (
  input logic clk,
  input logic rst,
  muxpga_cfg_loader_if.slave bus
);
  typedef enum logic [3:0] {IDLE, CLEAR, WAIT, SHIFT_HI, SHIFT_LO, CHECK, COMMIT, DONE, ERR} state_t;
  state_t state, state_n;
  logic [7:0] cnt, timer, byte_q;
  logic listen, take, expired;
`ifdef MUXPGA_CFG_CRC_EN
  localparam bit CRC_EN = 1'b1;
  logic [7:0] crc;
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? {r[6:0], 1'b0} ^ 8'h07 : {r[6:0], 1'b0};
    return r;
  endfunction
  assign listen = state == WAIT || state == CHECK;
`else
  localparam bit CRC_EN = 1'b0;
  assign listen = state == WAIT;
`endif
  assign take    = listen && bus.in_valid;
  assign expired = listen && !bus.in_valid && timer == 8'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: state_n = bus.start ? CLEAR : state;
      CLEAR:           state_n = WAIT;
      WAIT:            state_n = take ? SHIFT_HI : expired ? ERR : WAIT;
      SHIFT_HI:        state_n = SHIFT_LO;
      SHIFT_LO:        state_n = cnt < 8'(NUM_BYTES) ? WAIT : CHECK;
`ifdef MUXPGA_CFG_CRC_EN
      CHECK:           state_n = take ? (bus.in_data == crc ? COMMIT : ERR) : expired ? ERR : CHECK;
`else
      CHECK:           state_n = COMMIT;
`endif
      COMMIT:          state_n = DONE;
      default:         state_n = IDLE;
    endcase
    if (bus.abort && state inside {CLEAR, WAIT, SHIFT_HI, SHIFT_LO, CHECK, COMMIT}) state_n = ERR;
  end
  // outputs decode the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 8'h00;
      timer        <= 8'h00;
      byte_q       <= 8'h00;
`ifdef MUXPGA_CFG_CRC_EN
      crc          <= 8'h00;
`endif
      bus.cfg_cmd  <= 2'b00;
      bus.cfg_nib  <= 4'h0;
      bus.in_ready <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
    end else begin
      state        <= state_n;
      bus.cfg_cmd  <= state_n == CLEAR ? 2'b11 : state_n == COMMIT ? 2'b10 :
                      state_n inside {SHIFT_HI, SHIFT_LO} ? 2'b01 : 2'b00;
      bus.cfg_nib  <= state_n == SHIFT_HI ? bus.in_data[7:4] : state_n == SHIFT_LO ? byte_q[3:0] : 4'h0;
      bus.in_ready <= state_n == WAIT || (CRC_EN && state_n == CHECK);
      bus.busy     <= state_n inside {CLEAR, WAIT, SHIFT_HI, SHIFT_LO, CHECK, COMMIT};
      bus.done     <= state_n == DONE;
      bus.error    <= state_n == ERR;
      if (state_n == CLEAR) begin
        cnt   <= 8'h00;
        timer <= 8'h00;
`ifdef MUXPGA_CFG_CRC_EN
        crc   <= 8'h00;
`endif
      end else if (take) begin
        timer <= 8'h00;
        if (state == WAIT) begin
          cnt    <= cnt + 8'd1;
          byte_q <= bus.in_data;
`ifdef MUXPGA_CFG_CRC_EN
          crc    <= crc8(crc, bus.in_data);
`endif
        end
      end else if (listen) begin
        timer <= timer + 8'd1;
      end
    end
  end
endmodule
